// File: rtl/round_referee.sv
// Round referee: sequences play, decision, scoring and announce phases of a
// two-blob match and flags the round winner to the external score counter.
module round_referee #(
    parameter int WIN_POINTS      = 5,
    parameter int ROUND_FRAMES    = 1800,
    parameter int ANNOUNCE_FRAMES = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        white_eaten,
    input  logic        black_eaten,
    input  logic [9:0]  white_mass,
    input  logic [9:0]  black_mass,
    input  logic [7:0]  whitepoints,
    input  logic [7:0]  blackpoints,
    output logic        blackwon,
    output logic        whitewon,
    output logic        add,
    output logic        round_reset,
    output logic        match_over,
    output logic [2:0]  state_code,
    output logic [11:0] frames_left
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DECIDE    = 3'd2,
        SCORE     = 3'd3,
        ANNOUNCE  = 3'd4,
        MATCH_END = 3'd5
    } state_t;

    localparam logic [11:0] ROUND_LOAD = 12'(ROUND_FRAMES);
    localparam logic [15:0] ANN_MAX    = 16'(ANNOUNCE_FRAMES);
    localparam logic [7:0]  WIN_PTS    = 8'(WIN_POINTS);

    state_t      state_q, state_d;
    logic [11:0] frames_q, frames_d;
    logic [15:0] ann_q, ann_d;
    logic        ann_first_q, ann_first_d;
    logic        white_ate_q, white_ate_d;
    logic        black_ate_q, black_ate_d;
    logic        timeout_q, timeout_d;
    logic        blackwon_q, blackwon_d;
    logic        whitewon_q, whitewon_d;
    logic        add_q, add_d;
    logic        round_reset_q, round_reset_d;
    logic        match_over_q, match_over_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            frames_q      <= ROUND_LOAD;
            ann_q         <= '0;
            ann_first_q   <= 1'b0;
            white_ate_q   <= 1'b0;
            black_ate_q   <= 1'b0;
            timeout_q     <= 1'b0;
            blackwon_q    <= 1'b0;
            whitewon_q    <= 1'b0;
            add_q         <= 1'b0;
            round_reset_q <= 1'b1;
            match_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frames_q      <= frames_d;
            ann_q         <= ann_d;
            ann_first_q   <= ann_first_d;
            white_ate_q   <= white_ate_d;
            black_ate_q   <= black_ate_d;
            timeout_q     <= timeout_d;
            blackwon_q    <= blackwon_d;
            whitewon_q    <= whitewon_d;
            add_q         <= add_d;
            round_reset_q <= round_reset_d;
            match_over_q  <= match_over_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frames_d      = frames_q;
        ann_d         = ann_q;
        ann_first_d   = 1'b0;
        white_ate_d   = white_ate_q;
        black_ate_d   = black_ate_q;
        timeout_d     = timeout_q;
        blackwon_d    = blackwon_q;
        whitewon_d    = whitewon_q;
        add_d         = 1'b0;
        round_reset_d = 1'b1;
        match_over_d  = 1'b0;

        case (state_q)
            IDLE: begin
                frames_d = ROUND_LOAD;
                if (start) begin
                    state_d    = PLAY;
                    blackwon_d = 1'b0;
                    whitewon_d = 1'b0;
                end
            end

            PLAY: begin
                if (frame_tick && frames_q != '0) begin
                    frames_d = frames_q - 12'd1;
                end
                // Eaten cause wins over a timeout landing on the same cycle
                if (white_eaten || black_eaten) begin
                    state_d     = DECIDE;
                    white_ate_d = white_eaten;
                    black_ate_d = black_eaten;
                    timeout_d   = 1'b0;
                end else if (frame_tick && frames_q == 12'd1) begin
                    state_d     = DECIDE;
                    white_ate_d = 1'b0;
                    black_ate_d = 1'b0;
                    timeout_d   = 1'b1;
                end
            end

            DECIDE: begin
                state_d    = SCORE;
                blackwon_d = 1'b0;
                whitewon_d = 1'b0;
                if (white_ate_q && !black_ate_q) begin
                    blackwon_d = 1'b1;
                end else if (black_ate_q && !white_ate_q) begin
                    whitewon_d = 1'b1;
                end else if (white_mass > black_mass) begin
                    whitewon_d = 1'b1;
                end else if (black_mass > white_mass) begin
                    blackwon_d = 1'b1;
                end
                add_d = blackwon_d | whitewon_d;
            end

            SCORE: begin
                state_d     = ANNOUNCE;
                ann_d       = '0;
                ann_first_d = 1'b1;
            end

            ANNOUNCE: begin
                if (frame_tick && ann_q < ANN_MAX) begin
                    ann_d = ann_q + 16'd1;
                end
                // Points are read only after the counter has absorbed the add strobe
                if (!ann_first_q && ann_q >= ANN_MAX) begin
                    if (whitepoints >= WIN_PTS || blackpoints >= WIN_PTS) begin
                        state_d = MATCH_END;
                    end else begin
                        state_d    = PLAY;
                        frames_d   = ROUND_LOAD;
                        blackwon_d = 1'b0;
                        whitewon_d = 1'b0;
                    end
                end
            end

            MATCH_END: begin
                state_d = MATCH_END;
            end

            default: begin
                state_d  = IDLE;
                frames_d = ROUND_LOAD;
            end
        endcase

        round_reset_d = (state_d == IDLE) || (state_d == ANNOUNCE) ||
                        (state_d == MATCH_END);
        match_over_d  = (state_d == MATCH_END);
    end

    assign blackwon    = blackwon_q;
    assign whitewon    = whitewon_q;
    assign add         = add_q;
    assign round_reset = round_reset_q;
    assign match_over  = match_over_q;
    assign state_code  = state_q;
    assign frames_left = frames_q;

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee with short round/announce timing.
module tb_round_referee;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        start;
    logic        white_eaten;
    logic        black_eaten;
    logic [9:0]  white_mass;
    logic [9:0]  black_mass;
    logic [7:0]  whitepoints;
    logic [7:0]  blackpoints;
    logic        blackwon;
    logic        whitewon;
    logic        add;
    logic        round_reset;
    logic        match_over;
    logic [2:0]  state_code;
    logic [11:0] frames_left;

    int checks   = 0;
    int failures = 0;

    round_referee #(
        .WIN_POINTS(2),
        .ROUND_FRAMES(4),
        .ANNOUNCE_FRAMES(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_tick(frame_tick),
        .start(start),
        .white_eaten(white_eaten),
        .black_eaten(black_eaten),
        .white_mass(white_mass),
        .black_mass(black_mass),
        .whitepoints(whitepoints),
        .blackpoints(blackpoints),
        .blackwon(blackwon),
        .whitewon(whitewon),
        .add(add),
        .round_reset(round_reset),
        .match_over(match_over),
        .state_code(state_code),
        .frames_left(frames_left)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // From the first ANNOUNCE cycle: three ticks, then the expiry edge
    task automatic run_announce();
        repeat (3) pulse_tick();
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_code); end
        checks++; if (round_reset !== 1'b1) begin failures++; $display("FAIL reset_rr got=%b exp=1", round_reset); end
        checks++; if (frames_left !== 12'd4) begin failures++; $display("FAIL reset_frames got=%0d exp=4", frames_left); end
        checks++; if ({blackwon, whitewon, add, match_over} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {blackwon, whitewon, add, match_over}); end
        white_eaten = 1'b1;
        step();
        white_eaten = 1'b0;
        checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL idle_ignores_eaten got=%0d exp=0", state_code); end
    endtask

    task automatic test_white_eaten();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (state_code !== 3'd1) begin failures++; $display("FAIL play_entry got=%0d exp=1", state_code); end
        checks++; if (round_reset !== 1'b0) begin failures++; $display("FAIL play_rr got=%b exp=0", round_reset); end
        checks++; if (frames_left !== 12'd4) begin failures++; $display("FAIL play_frames got=%0d exp=4", frames_left); end
        repeat (9) step();
        white_eaten = 1'b1;
        step();
        white_eaten = 1'b0;
        checks++; if (state_code !== 3'd2 || add !== 1'b0) begin failures++; $display("FAIL we_decide state=%0d add=%b exp=2/0", state_code, add); end
        step();
        checks++; if (state_code !== 3'd3) begin failures++; $display("FAIL we_score_state got=%0d exp=3", state_code); end
        checks++; if ({blackwon, whitewon, add} !== 3'b101) begin failures++; $display("FAIL we_score_flags bw/ww/add got=%b exp=101", {blackwon, whitewon, add}); end
        step();
        checks++; if (state_code !== 3'd4 || add !== 1'b0 || round_reset !== 1'b1 || blackwon !== 1'b1) begin failures++; $display("FAIL we_announce state=%0d add=%b rr=%b bw=%b exp=4/0/1/1", state_code, add, round_reset, blackwon); end
    endtask

    task automatic test_return_to_play();
        repeat (3) pulse_tick();
        checks++; if (state_code !== 3'd4) begin failures++; $display("FAIL ann_hold got=%0d exp=4", state_code); end
        step();
        checks++; if (state_code !== 3'd1 || frames_left !== 12'd4) begin failures++; $display("FAIL ann_to_play state=%0d frames=%0d exp=1/4", state_code, frames_left); end
        checks++; if ({round_reset, blackwon, whitewon} !== 3'b000) begin failures++; $display("FAIL ann_to_play_flags got=%b exp=000", {round_reset, blackwon, whitewon}); end
    endtask

    task automatic test_timeout();
        white_mass = 10'd20;
        black_mass = 10'd30;
        repeat (3) pulse_tick();
        checks++; if (state_code !== 3'd1 || frames_left !== 12'd1) begin failures++; $display("FAIL to_countdown state=%0d frames=%0d exp=1/1", state_code, frames_left); end
        pulse_tick();
        checks++; if (state_code !== 3'd2 || frames_left !== 12'd0) begin failures++; $display("FAIL to_decide state=%0d frames=%0d exp=2/0", state_code, frames_left); end
        step();
        checks++; if ({blackwon, whitewon, add} !== 3'b101) begin failures++; $display("FAIL to_mass_winner bw/ww/add got=%b exp=101", {blackwon, whitewon, add}); end
        step();
        run_announce();
        white_mass = 10'd25;
        black_mass = 10'd25;
        repeat (4) pulse_tick();
        checks++; if (state_code !== 3'd2) begin failures++; $display("FAIL draw_decide got=%0d exp=2", state_code); end
        step();
        checks++; if (state_code !== 3'd3 || {blackwon, whitewon, add} !== 3'b000) begin failures++; $display("FAIL draw_score state=%0d bw/ww/add=%b exp=3/000", state_code, {blackwon, whitewon, add}); end
        step();
        checks++; if (state_code !== 3'd4 || add !== 1'b0) begin failures++; $display("FAIL draw_announce state=%0d add=%b exp=4/0", state_code, add); end
        run_announce();
    endtask

    task automatic test_eaten_priority();
        white_mass = 10'd50;
        black_mass = 10'd40;
        repeat (3) pulse_tick();
        white_eaten = 1'b1;
        frame_tick  = 1'b1;
        step();
        white_eaten = 1'b0;
        frame_tick  = 1'b0;
        checks++; if (state_code !== 3'd2) begin failures++; $display("FAIL prio_decide got=%0d exp=2", state_code); end
        step();
        checks++; if ({blackwon, whitewon, add} !== 3'b101) begin failures++; $display("FAIL prio_eaten_wins bw/ww/add got=%b exp=101", {blackwon, whitewon, add}); end
        step();
        run_announce();
    endtask

    task automatic test_both_eaten();
        checks++; if (state_code !== 3'd1) begin failures++; $display("FAIL both_pre_play got=%0d exp=1", state_code); end
        white_eaten = 1'b1;
        black_eaten = 1'b1;
        step();
        white_eaten = 1'b0;
        black_eaten = 1'b0;
        step();
        checks++; if (state_code !== 3'd3 || {blackwon, whitewon, add} !== 3'b011) begin failures++; $display("FAIL both_score state=%0d bw/ww/add=%b exp=3/011", state_code, {blackwon, whitewon, add}); end
        step();
        checks++; if (add !== 1'b0 || whitewon !== 1'b1) begin failures++; $display("FAIL both_single_add add=%b ww=%b exp=0/1", add, whitewon); end
        run_announce();
    endtask

    task automatic test_reset_in_score();
        pulse_tick();
        white_eaten = 1'b1;
        step();
        white_eaten = 1'b0;
        step();
        checks++; if (state_code !== 3'd3 || add !== 1'b1) begin failures++; $display("FAIL rs_pre state=%0d add=%b exp=3/1", state_code, add); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++; if (state_code !== 3'd0 || add !== 1'b0) begin failures++; $display("FAIL rs_state_add state=%0d add=%b exp=0/0", state_code, add); end
        checks++; if (round_reset !== 1'b1 || frames_left !== 12'd4) begin failures++; $display("FAIL rs_rr_frames rr=%b frames=%0d exp=1/4", round_reset, frames_left); end
        checks++; if ({blackwon, whitewon, match_over} !== 3'b000) begin failures++; $display("FAIL rs_flags got=%b exp=000", {blackwon, whitewon, match_over}); end
    endtask

    task automatic test_match_end();
        start = 1'b1;
        step();
        start = 1'b0;
        white_eaten = 1'b1;
        step();
        white_eaten = 1'b0;
        step();
        blackpoints = 8'd2;
        step();
        checks++; if (state_code !== 3'd4) begin failures++; $display("FAIL me_announce got=%0d exp=4", state_code); end
        run_announce();
        checks++; if (state_code !== 3'd5 || match_over !== 1'b1) begin failures++; $display("FAIL me_enter state=%0d mo=%b exp=5/1", state_code, match_over); end
        checks++; if (round_reset !== 1'b1 || blackwon !== 1'b1 || whitewon !== 1'b0) begin failures++; $display("FAIL me_flags rr=%b bw=%b ww=%b exp=1/1/0", round_reset, blackwon, whitewon); end
        start = 1'b1;
        repeat (5) step();
        start = 1'b0;
        checks++; if (state_code !== 3'd5 || match_over !== 1'b1) begin failures++; $display("FAIL me_start_ignored state=%0d mo=%b exp=5/1", state_code, match_over); end
    endtask

    initial begin
        Reset       = 1'b1;
        frame_tick  = 1'b0;
        start       = 1'b0;
        white_eaten = 1'b0;
        black_eaten = 1'b0;
        white_mass  = '0;
        black_mass  = '0;
        whitepoints = '0;
        blackpoints = '0;
        test_reset();
        test_white_eaten();
        test_return_to_play();
        test_timeout();
        test_eaten_priority();
        test_both_eaten();
        test_reset_in_score();
        test_match_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_referee.md
ROUND_REFEREE -- requirements
Module: round_referee

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIN_POINTS, 5, points that end the match; ROUND_FRAMES, 1800, frame ticks per round before timeout; ANNOUNCE_FRAMES, 120, frame ticks winner is shown between rounds.
REQ-002 Clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Reset  in  1  reset Reset, synchronous, active-high; clock Clk.
REQ-004 frame_tick  in  1  one-Clk-cycle pulse per video frame.
REQ-005 start  in  1  player start button, level, already synchronized.
REQ-006 white_eaten  in  1  white blob consumed this cycle (level, game logic).
REQ-007 black_eaten  in  1  black blob consumed this cycle.
REQ-008 white_mass  in  10  current white blob mass, unsigned.
REQ-009 black_mass  in  10  current black blob mass, unsigned.
REQ-010 whitepoints  in  8  white total read back from score counter.
REQ-011 blackpoints  in  8  black total read back from score counter.
REQ-012 blackwon  out  1  black won last decided round; registered.
REQ-013 whitewon  out  1  white won last decided round; registered.
REQ-014 add  out  1  one-cycle strobe: score counter increments the flagged winner.
REQ-015 round_reset  out  1  high while blobs must be held at spawn positions.
REQ-016 match_over  out  1  a player reached WIN_POINTS.
REQ-017 state_code  out  3  IDLE=0, PLAY=1, DECIDE=2, SCORE=3, ANNOUNCE=4, MATCH_END=5.
REQ-018 frames_left  out  12  remaining round frames, unsigned.

Function
REQ-019 All outputs SHALL be registered; no combinational input-to-output path.
REQ-020 IDLE: round_reset=1, frames_left loaded with ROUND_FRAMES; start=1 -> PLAY next cycle.
REQ-021 PLAY: round_reset=0; blackwon=whitewon=0 on entry; each frame_tick decrements frames_left by 1, never below 0.
REQ-022 PLAY exit: white_eaten|black_eaten in any cycle, or frame_tick while frames_left==1 (count reaches 0) -> DECIDE; eaten flags and timeout cause SHALL be latched on that edge; inputs ignored outside PLAY.
REQ-023 Eaten and timeout on same cycle: eaten cause SHALL take priority.
REQ-024 DECIDE (exactly 1 cycle): white_eaten only -> blackwon=1; black_eaten only -> whitewon=1; both eaten or timeout -> larger mass (sampled in DECIDE) wins; equal mass -> draw, both flags 0.
REQ-025 blackwon and whitewon SHALL never be 1 simultaneously; set in DECIDE, held through SCORE, ANNOUNCE and MATCH_END.
REQ-026 SCORE (exactly 1 cycle): add=1 iff a winner flag is set; add=0 on draw; add SHALL be 1 in no other state, so one round yields at most one add pulse.
REQ-027 ANNOUNCE: round_reset=1; counts ANNOUNCE_FRAMES frame_ticks; first cycle SHALL not evaluate points (counter update latency 1 cycle).
REQ-028 ANNOUNCE expiry: whitepoints>=WIN_POINTS or blackpoints>=WIN_POINTS -> MATCH_END; else reload frames_left=ROUND_FRAMES -> PLAY (no start press needed).
REQ-029 MATCH_END: match_over=1, round_reset=1, winner flags held; start ignored; exit only via Reset.
REQ-030 Undefined state_code values SHALL return to IDLE next cycle.
REQ-031 Point comparisons 8-bit unsigned; WIN_POINTS must be 1..255.

Reset
REQ-032 Reset SHALL override all activity in any state, including mid-SCORE: next cycle state=IDLE, blackwon=whitewon=add=match_over=0, round_reset=1, frames_left=ROUND_FRAMES, internal counters and latched causes cleared.
REQ-033 Reset SHALL NOT be required to clear the score counter; system Reset drives both blocks.

Verification
REQ-034 Reset, start=1, white_eaten pulse 10 cycles later -> DECIDE, SCORE with blackwon=1, add=1 exactly one cycle, whitewon=0.
REQ-035 ROUND_FRAMES=4, no eaten, white_mass=20, black_mass=30 -> DECIDE after 4th frame_tick, blackwon=1, add pulse; masses equal instead -> add never asserted, both flags 0.
REQ-036 white_eaten and black_eaten same cycle, white_mass=50, black_mass=40 -> whitewon=1, one add pulse.
REQ-037 WIN_POINTS=2, blackpoints=2 presented after SCORE -> ANNOUNCE expiry -> MATCH_END, match_over=1; later start=1 -> stays MATCH_END.
REQ-038 Reset asserted during SCORE -> next cycle add=0, state_code=0, round_reset=1, frames_left=ROUND_FRAMES.
REQ-039 Points below WIN_POINTS at ANNOUNCE expiry -> PLAY, frames_left=ROUND_FRAMES, round_reset=0, flags cleared.
